// File: rtl/color_pkg.sv
// Shared types, widths and the per-digit 12-bit RGB palette.
// Also holds the digit-to-colour lookup used by color_codes.
package color_pkg;
   localparam int NUM_W   = 6;
   localparam int CODE_W  = 24;
   localparam int DIGIT_W = 12;

   localparam logic [DIGIT_W-1:0] COL_BLACK   = 12'h000;
   localparam logic [DIGIT_W-1:0] COL_RED     = 12'hF00;
   localparam logic [DIGIT_W-1:0] COL_ORANGE  = 12'hF80;
   localparam logic [DIGIT_W-1:0] COL_YELLOW  = 12'hFF0;
   localparam logic [DIGIT_W-1:0] COL_GREEN   = 12'h0F0;
   localparam logic [DIGIT_W-1:0] COL_CYAN    = 12'h0FF;
   localparam logic [DIGIT_W-1:0] COL_AZURE   = 12'h08F;
   localparam logic [DIGIT_W-1:0] COL_BLUE    = 12'h00F;
   localparam logic [DIGIT_W-1:0] COL_MAGENTA = 12'hF0F;
   localparam logic [DIGIT_W-1:0] COL_WHITE   = 12'hFFF;

   typedef enum logic {S_EMPTY, S_FULL} slot_state_t;

   function automatic logic [DIGIT_W-1:0] digit_color(input logic [3:0] digit);
      case (digit)
         4'd0:    return COL_BLACK;
         4'd1:    return COL_RED;
         4'd2:    return COL_ORANGE;
         4'd3:    return COL_YELLOW;
         4'd4:    return COL_GREEN;
         4'd5:    return COL_CYAN;
         4'd6:    return COL_AZURE;
         4'd7:    return COL_BLUE;
         4'd8:    return COL_MAGENTA;
         4'd9:    return COL_WHITE;
         default: return COL_BLACK;
      endcase
   endfunction
endpackage

// File: rtl/color_codes.sv
// Combinational 6-bit number to two-digit RGB code: {colour(tens), colour(ones)}.
module color_codes
   import color_pkg::*;
(
   input  logic [NUM_W-1:0]  i_num,
   output logic [CODE_W-1:0] o_code
);
   always_comb begin
      o_code = {digit_color(4'(i_num / NUM_W'(10))), digit_color(4'(i_num % NUM_W'(10)))};
   end
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above i_ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_gnt,
   output logic [W-1:0] o_idx
);
   logic found;
   int   k;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      found = 1'b0;
      k     = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(i_ptr) + i) % N;
         if (!found && i_req[k]) begin
            found    = 1'b1;
            o_gnt[k] = 1'b1;
            o_idx    = W'(k);
         end
      end
   end
endmodule

// File: rtl/color_code_scheduler.sv
// Round-robin sharing of one color_codes lookup among NUM_REQ requesters,
// with the result held in a single-entry valid/ready output slot.
module color_code_scheduler
   import color_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ-1:0]       i_req,
   input  logic [NUM_REQ*NUM_W-1:0] i_num,
   output logic [NUM_REQ-1:0]       o_gnt,
   output logic                     o_valid,
   output logic [CODE_W-1:0]        o_code,
   output logic [ID_W-1:0]          o_id,
   input  logic                     i_ready
);
   slot_state_t        state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]    arb_idx;
   logic [NUM_W-1:0]   num_sel;
   logic [CODE_W-1:0]  lookup_code;
   logic               accept;

   rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_arb (
      .i_req (i_req),
      .i_ptr (ptr_q),
      .o_gnt (arb_gnt),
      .o_idx (arb_idx)
   );

   color_codes u_codes (
      .i_num  (num_sel),
      .o_code (lookup_code)
   );

   always_comb begin
      // A full slot only frees up for a new capture when the consumer takes it this cycle.
      accept  = (|i_req) & ((state_q == S_EMPTY) | i_ready);
      o_gnt   = (accept && !i_rst) ? arb_gnt : '0;
      num_sel = i_num[int'(arb_idx)*NUM_W +: NUM_W];

      ptr_d   = ptr_q;
      code_d  = code_q;
      id_d    = id_q;
      state_d = state_q;
      if (accept) begin
         ptr_d   = ID_W'((int'(arb_idx) + 1) % NUM_REQ);
         code_d  = lookup_code;
         id_d    = arb_idx;
         state_d = S_FULL;
      end else if (i_ready) begin
         state_d = S_EMPTY;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_EMPTY;
         ptr_q   <= '0;
         code_q  <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         code_q  <= code_d;
         id_q    <= id_d;
      end
   end

   assign o_valid = (state_q == S_FULL);
   assign o_code  = code_q;
   assign o_id    = id_q;
endmodule

// File: tb/tb_color_code_scheduler.sv
// Directed bench for color_code_scheduler: reset, arbitration order, backpressure, wrap and full lookup table.
module tb_color_code_scheduler;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [23:0] num;
   logic [3:0]  gnt;
   logic        valid;
   logic [23:0] code;
   logic [1:0]  id;
   logic        ready;

   int n_checks = 0;
   int n_errors = 0;

   logic [23:0] rr_codes [4];
   int          rr_nums  [4];

   always #5 clk = ~clk;

   color_code_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_num   (num),
      .o_gnt   (gnt),
      .o_valid (valid),
      .o_code  (code),
      .o_id    (id),
      .i_ready (ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref_digit(input int d);
      case (d)
         0: return 12'h000;
         1: return 12'hF00;
         2: return 12'hF80;
         3: return 12'hFF0;
         4: return 12'h0F0;
         5: return 12'h0FF;
         6: return 12'h08F;
         7: return 12'h00F;
         8: return 12'hF0F;
         9: return 12'hFFF;
         default: return 12'hBAD;
      endcase
   endfunction

   function automatic logic [23:0] ref_code(input int n);
      return {ref_digit(n / 10), ref_digit(n % 10)};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [23:0] exp_code, input logic [1:0] exp_id);
      $display("xfer %s: valid=%0b id=%0d code=%h", tag, valid, id, code);
      check({tag, " valid"}, 32'(valid), 32'd1);
      check({tag, " code"}, 32'(code), 32'(exp_code));
      check({tag, " id"}, 32'(id), 32'(exp_id));
   endtask

   initial begin
      rr_nums  = '{5, 12, 40, 63};
      rr_codes = '{24'h0000FF, 24'hF00F80, 24'h0F0000, 24'h08FFF0};
      rst   = 1'b1;
      req   = '0;
      num   = '0;
      ready = 1'b0;

      // Reset state
      step;
      step;
      check("rst valid", 32'(valid), 32'd0);
      check("rst code", 32'(code), 32'd0);
      check("rst id", 32'(id), 32'd0);
      check("rst gnt", 32'(gnt), 32'd0);
      rst   = 1'b0;
      ready = 1'b1;

      // Single request
      req = 4'b0001;
      num[0 +: 6] = 6'd37;
      #1 check("single gnt", 32'(gnt), 32'b0001);
      step;
      req = '0;
      check_out("single", 24'hFF000F, 2'd0);
      #1 check("idle gnt", 32'(gnt), 32'd0);
      step;
      check("drain valid", 32'(valid), 32'd0);

      // Wrap from ptr=1 to requester 3, pointer returns to 0
      req = 4'b1000;
      num[18 +: 6] = 6'd9;
      #1 check("wrap3 gnt", 32'(gnt), 32'b1000);
      step;
      check_out("wrap3", 24'h000FFF, 2'd3);

      // Round robin with all requesters active
      req = 4'b1111;
      for (int k = 0; k < 4; k++) num[6*k +: 6] = 6'(rr_nums[k]);
      for (int c = 0; c < 5; c++) begin
         logic [3:0] eg;
         eg = 4'b0001 << (c % 4);
         #1 check($sformatf("rr gnt %0d", c), 32'(gnt), 32'(eg));
         step;
         check_out($sformatf("rr %0d", c), rr_codes[c % 4], 2'(c % 4));
      end

      // Backpressure: slot holds, no grants
      ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 check($sformatf("bp gnt %0d", c), 32'(gnt), 32'd0);
         step;
         check_out($sformatf("bp hold %0d", c), 24'h0000FF, 2'd0);
      end
      ready = 1'b1;
      #1 check("bp release gnt", 32'(gnt), 32'b0010);
      step;
      check_out("bp release", 24'hF00F80, 2'd1);
      req = '0;
      #1 check("bp idle gnt", 32'(gnt), 32'd0);
      step;
      check("bp drain valid", 32'(valid), 32'd0);

      // Drive ptr to 3, then wrap and skip idle requester 0
      req = 4'b0100;
      num[12 +: 6] = 6'd0;
      #1 check("pre gnt", 32'(gnt), 32'b0100);
      step;
      check_out("pre", 24'h000000, 2'd2);
      req = 4'b1010;
      num[6 +: 6]  = 6'd21;
      num[18 +: 6] = 6'd50;
      #1 check("wrap gnt", 32'(gnt), 32'b1000);
      step;
      check_out("wrap", 24'h0FF000, 2'd3);
      req = 4'b0010;
      #1 check("skip gnt", 32'(gnt), 32'b0010);
      step;
      check_out("skip", 24'hF80F00, 2'd1);

      // Every number through requester 2
      req = 4'b0100;
      for (int n = 0; n < 64; n++) begin
         num[12 +: 6] = 6'(n);
         #1 check($sformatf("exh gnt %0d", n), 32'(gnt), 32'b0100);
         step;
         check_out($sformatf("exh %0d", n), ref_code(n), 2'd2);
      end

      // Reset mid-transfer: ptr left at 1, then reset must return it to 0
      req = 4'b0001;
      num[0 +: 6] = 6'd37;
      step;
      check_out("pre-rst", 24'hFF000F, 2'd0);
      rst = 1'b1;
      req = 4'b0011;
      #1;
      check("mid rst valid", 32'(valid), 32'd0);
      check("mid rst code", 32'(code), 32'd0);
      check("mid rst id", 32'(id), 32'd0);
      check("mid rst gnt", 32'(gnt), 32'd0);
      step;
      rst = 1'b0;
      check("post rst valid", 32'(valid), 32'd0);
      #1 check("post rst gnt", 32'(gnt), 32'b0001);
      step;
      check_out("post rst", 24'hFF000F, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
